// File: rtl/latch_response_checker.sv
// ---------------------------------------------------------------------------
// latch_response_checker
// Golden-model response checker for a transparent D-latch. It accepts one
// {e,d} vector at a time, waits for the latch outputs to settle, then compares
// the observed q/q_bar against a reference latch model. It reports pass/fail,
// a saturating error count and the index of the first failing vector.
//
// Build option:
//   LATCH_CHK_HALT_EN - when defined, the first mismatch ends the run
//                       immediately and no further vectors are requested.
// ---------------------------------------------------------------------------
module latch_response_checker #(
  parameter int NUM_VECTORS = 4,
  parameter int IDX_W       = 4,
  parameter int ERR_W       = 8,
  parameter int SETTLE_CYC  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic             e,
  input  logic             d,
  input  logic             q,
  input  logic             q_bar,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [IDX_W-1:0] first_err_idx
);

  // Settle counter only has to reach SETTLE_CYC-1.
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VECTORS - 1);
  localparam logic [IDX_W-1:0] IDX_NONE = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ZERO = {ERR_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_VEC = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_COMPARE  = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  // Error counter increment that sticks at the top value instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] val);
    logic [ERR_W-1:0] res;
    if (val == ERR_MAX) begin
      res = val;
    end else begin
      res = val + ERR_W'(1);
    end
    return res;
  endfunction

  // Registered state
  state_t           state_r;
  logic [IDX_W-1:0] idx_r;
  logic [CNT_W-1:0] cnt_r;
  logic [ERR_W-1:0] err_r;
  logic [IDX_W-1:0] ferr_r;
  logic             model_q_r;
  logic             model_known_r;
  logic             vec_ready_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;

  // Next-state values
  state_t           state_nxt_s;
  logic [IDX_W-1:0] idx_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [ERR_W-1:0] err_nxt_s;
  logic [IDX_W-1:0] ferr_nxt_s;
  logic             model_q_nxt_s;
  logic             model_known_nxt_s;
  logic             pass_nxt_s;
  logic             mismatch_s;
  logic             accept_s;

  // Handshake fires only while the checker is actually advertising ready.
  always_comb begin
    accept_s = vec_valid & vec_ready_r;
  end

  // Compare observed latch outputs with the reference model; X/Z counts as bad.
  always_comb begin
    mismatch_s = 1'b0;
    if (q_bar !== ~q) begin
      mismatch_s = 1'b1;
    end else if (model_known_r && (q !== model_q_r)) begin
      mismatch_s = 1'b1;
    end else begin
      mismatch_s = 1'b0;
    end
  end

  // Run sequencing, reference-model update and error bookkeeping.
  always_comb begin
    state_nxt_s       = state_r;
    idx_nxt_s         = idx_r;
    cnt_nxt_s         = cnt_r;
    err_nxt_s         = err_r;
    ferr_nxt_s        = ferr_r;
    model_q_nxt_s     = model_q_r;
    model_known_nxt_s = model_known_r;
    pass_nxt_s        = pass_r;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt_s       = ST_WAIT_VEC;
          idx_nxt_s         = IDX_ZERO;
          cnt_nxt_s         = CNT_ZERO;
          err_nxt_s         = ERR_ZERO;
          ferr_nxt_s        = IDX_NONE;
          model_known_nxt_s = 1'b0;
          pass_nxt_s        = 1'b0;
        end else begin
          state_nxt_s = state_r;
        end
      end

      ST_WAIT_VEC: begin
        if (accept_s) begin
          state_nxt_s = ST_SETTLE;
          cnt_nxt_s   = CNT_ZERO;
          // A transparent latch follows d while enabled and holds otherwise.
          if (e) begin
            model_q_nxt_s     = d;
            model_known_nxt_s = 1'b1;
          end else begin
            model_q_nxt_s     = model_q_r;
            model_known_nxt_s = model_known_r;
          end
        end else begin
          state_nxt_s = ST_WAIT_VEC;
        end
      end

      ST_SETTLE: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_COMPARE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = ST_SETTLE;
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end

      ST_COMPARE: begin
        if (mismatch_s) begin
          err_nxt_s = sat_inc(err_r);
          if (ferr_r == IDX_NONE) begin
            ferr_nxt_s = idx_r;
          end else begin
            ferr_nxt_s = ferr_r;
          end
        end else begin
          err_nxt_s  = err_r;
          ferr_nxt_s = ferr_r;
        end

        idx_nxt_s = idx_r + IDX_W'(1);

`ifdef LATCH_CHK_HALT_EN
        if (mismatch_s) begin
          state_nxt_s = ST_DONE;
        end else if (idx_r < IDX_LAST) begin
          state_nxt_s = ST_WAIT_VEC;
        end else begin
          state_nxt_s = ST_DONE;
        end
`else
        if (idx_r < IDX_LAST) begin
          state_nxt_s = ST_WAIT_VEC;
        end else begin
          state_nxt_s = ST_DONE;
        end
`endif

        // The verdict includes the compare happening this cycle.
        if (state_nxt_s == ST_DONE) begin
          pass_nxt_s = (err_nxt_s == ERR_ZERO);
        end else begin
          pass_nxt_s = 1'b0;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      idx_r         <= IDX_ZERO;
      cnt_r         <= CNT_ZERO;
      err_r         <= ERR_ZERO;
      ferr_r        <= IDX_NONE;
      model_q_r     <= 1'b0;
      model_known_r <= 1'b0;
      pass_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      idx_r         <= idx_nxt_s;
      cnt_r         <= cnt_nxt_s;
      err_r         <= err_nxt_s;
      ferr_r        <= ferr_nxt_s;
      model_q_r     <= model_q_nxt_s;
      model_known_r <= model_known_nxt_s;
      pass_r        <= pass_nxt_s;
    end
  end

  // Status flags are decoded from the upcoming state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      vec_ready_r <= (state_nxt_s == ST_WAIT_VEC);
      busy_r      <= (state_nxt_s == ST_WAIT_VEC) ||
                     (state_nxt_s == ST_SETTLE)   ||
                     (state_nxt_s == ST_COMPARE);
      done_r      <= (state_nxt_s == ST_DONE);
    end
  end

  assign vec_ready     = vec_ready_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign pass          = pass_r;
  assign err_count     = err_r;
  assign first_err_idx = ferr_r;

endmodule
